// File: rtl/bit_stream_serializer.sv
// Parallel-in, serial-out stage feeding the 101 sequence detector.
// Accepts WIDTH-bit words on a valid/ready handshake and emits one bit per
// clock. A new word can be taken on the last bit of the current one, so
// consecutive words stream out with no idle gap.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no word in flight; serial_out parked at IDLE_LEVEL, ready=1
// SHIFT | word in flight; one bit per clock, ready only on last bit
module bit_stream_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0,
    localparam int CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_done,
    output logic [CW-1:0]    bit_index
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] shifted;
    logic             last_bit;
    logic             accept;

    // Ready depends on registered state only, never on din_valid.
    assign last_bit  = (state == SHIFT) && (cnt == LAST);
    assign din_ready = (state == IDLE) || last_bit;
    assign accept    = din_valid && din_ready;

    // Shift toward the output end so the next bit lands on the tapped position.
    assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                               : {1'b0, shreg[WIDTH-1:1]};

    // State, shift register and bit counter; async reset discards any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: load on accept, shift mid-word, reload or drop to IDLE on last bit.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    shreg_nxt = din;
                    cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                if (cnt != LAST) begin
                    shreg_nxt = shifted;
                    cnt_nxt   = cnt + 1'b1;
                end else if (accept) begin
                    shreg_nxt = din;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = IDLE;
                    shreg_nxt = '0;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                shreg_nxt = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs come straight from registers; din never reaches serial_out combinationally.
    always_comb begin
        serial_valid = (state == SHIFT);
        if (state == SHIFT) begin
            serial_out = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        end else begin
            serial_out = IDLE_LEVEL;
        end
        frame_done = last_bit;
        bit_index  = cnt;
    end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Bench for bit_stream_serializer: one MSB-first and one LSB-first instance,
// compared every cycle against a word-level model (remaining-bit count and
// the word being sent), plus directed pattern checks and random traffic.
module tb_bit_stream_serializer;

    localparam int W = 8;

    logic         clk = 1'b1;
    logic         rst_n = 1'b0;
    logic [W-1:0] din_m = '0, din_l = '0;
    logic         val_m = 1'b0, val_l = 1'b0;
    logic         rdy_m, so_m, sv_m, fd_m;
    logic         rdy_l, so_l, sv_l, fd_l;
    logic [2:0]   idx_m, idx_l;

    int checks = 0;
    int errors = 0;

    // Model: rem = bits of the current word still to be shown (0 = idle).
    int           rem [2] = '{0, 0};
    logic [W-1:0] word [2];
    bit           acc [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    bit_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .din(din_m), .din_valid(val_m), .din_ready(rdy_m),
        .serial_out(so_m), .serial_valid(sv_m), .frame_done(fd_m), .bit_index(idx_m)
    );

    bit_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .din(din_l), .din_valid(val_l), .din_ready(rdy_l),
        .serial_out(so_l), .serial_valid(sv_l), .frame_done(fd_l), .bit_index(idx_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            bit    v;
            int    k;
            logic  eb;
            string p;
            v  = (rem[i] > 0);
            k  = W - rem[i];
            p  = (i == 0) ? "msb" : "lsb";
            if (!v)          eb = 1'b0;
            else if (i == 0) eb = word[i][W-1-k];
            else             eb = word[i][k];
            chk({p, "_serial_valid"}, (i == 0) ? sv_m : sv_l, v);
            chk({p, "_serial_out"},   (i == 0) ? so_m : so_l, eb);
            chk({p, "_frame_done"},   (i == 0) ? fd_m : fd_l, (rem[i] == 1));
            chk({p, "_din_ready"},    (i == 0) ? rdy_m : rdy_l, (rem[i] <= 1));
            chk({p, "_bit_index"},    (i == 0) ? idx_m : idx_l, v ? k : 0);
        end
    endtask

    task automatic step();
        logic         v;
        logic [W-1:0] d;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            v      = (i == 0) ? val_m : val_l;
            d      = (i == 0) ? din_m : din_l;
            acc[i] = 1'b0;
            if (!rst_n) begin
                rem[i] = 0;
            end else if (v && rem[i] <= 1) begin
                word[i] = d;
                rem[i]  = W;
                acc[i]  = 1'b1;
            end else if (rem[i] > 0) begin
                rem[i]--;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic send(input int i, input logic [W-1:0] d);
        int n;
        n = 0;
        if (i == 0) begin din_m = d; val_m = 1'b1; end
        else        begin din_l = d; val_l = 1'b1; end
        do begin
            step();
            n++;
        end while (!acc[i] && n < 3 * W);
        chk("accept_within_bound", acc[i], 1'b1);
        if (i == 0) val_m = 1'b0;
        else        val_l = 1'b0;
    endtask

    initial begin
        logic [W-1:0] pat;

        // Reset held with din_valid high: idle outputs, nothing accepted.
        din_m = 8'hFF; din_l = 8'hFF; val_m = 1'b1; val_l = 1'b1;
        #1;
        check_outputs();
        step();
        #3;
        val_m = 1'b0; val_l = 1'b0;
        rst_n = 1'b1;
        step();

        // Single word, MSB first, checked against the literal bit pattern too.
        pat = 8'b1010_0000;
        send(0, pat);
        for (int i = 0; i < W; i++) begin
            chk("single_bit", so_m, pat[W-1-i]);
            chk("single_idx", idx_m, i);
            chk("single_frame_done", fd_m, (i == W - 1));
            if (i < W - 1) step();
        end
        step();
        chk("single_back_to_idle", sv_m, 1'b0);

        // Back-to-back words: no gap between A5 and 5A.
        send(0, 8'hA5);
        send(0, 8'h5A);
        chk("b2b_gapless_valid", sv_m, 1'b1);
        repeat (W + 1) step();

        // LSB-first instance.
        send(1, 8'h0D);
        repeat (W + 1) step();

        // Busy rejection: 00 offered mid-word is ignored until the last bit.
        send(0, 8'hFF);
        step();
        din_m = 8'h00; val_m = 1'b1;
        repeat (4) begin
            step();
            chk("busy_ready_low", rdy_m, 1'b0);
            chk("busy_bit_kept", so_m, 1'b1);
        end
        send(0, 8'h00);
        repeat (W + 1) step();

        // Reset mid-word: outputs drop at once, next word has no residue.
        send(0, 8'hA5);
        step();
        step();
        #3;
        rst_n = 1'b0;
        rem[0] = 0; rem[1] = 0;
        #1;
        check_outputs();
        chk("midreset_valid_now", sv_m, 1'b0);
        step();
        #3;
        rst_n = 1'b1;
        send(0, 8'h80);
        repeat (W + 1) step();

        // Random traffic on both instances.
        repeat (400) begin
            val_m = ($urandom_range(3) != 0);
            val_l = ($urandom_range(3) != 0);
            din_m = W'($urandom);
            din_l = W'($urandom);
            step();
        end
        val_m = 1'b0; val_l = 1'b0;
        repeat (W + 1) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_stream_serializer.md
Name: bit_stream_serializer

Overview:
- Parallel-in, serial-out stage directly upstream of the 101 sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock on serial_out, which drives the detector's serial input.
- Supports gapless back-to-back words, so the detector sees a continuous bit stream across word boundaries.
- serial_valid qualifies each bit; frame_done marks the last bit of each word.

Parameters:
- WIDTH, 8, word width in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
- IDLE_LEVEL, 0, value driven on serial_out while no word is being shifted.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous and active-low.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a valid word.
- din_ready  output  1  block can accept a word this cycle.
- serial_out  output  1  serial bit stream to the detector.
- serial_valid  output  1  serial_out carries a data bit this cycle.
- frame_done  output  1  high during the last bit of a word.
- bit_index  output  $clog2(WIDTH)  index of the current bit within the word, counting 0..WIDTH-1 in transmit order.

Behaviour:
- Clock and reset: one clock (clk); asynchronous active-low reset (rst_n).
- Reset values, applied immediately when rst_n falls, with no clock needed:
  - state = IDLE, shift register = 0, bit counter = 0.
  - serial_out = IDLE_LEVEL, serial_valid = 0, frame_done = 0, bit_index = 0, din_ready = 1.
- FSM states: IDLE, SHIFT.
- Transfer rule: a word is accepted at a posedge where din_valid && din_ready.
- din_ready:
  - 1 in IDLE.
  - 1 in SHIFT only when the bit counter = WIDTH-1 (last bit); 0 otherwise.
  - Never depends combinationally on din_valid.
- IDLE -> SHIFT on accept: load the shift register with din, clear the counter.
- Latency: the first bit appears on serial_out in the cycle immediately after the accepting edge.
- SHIFT, counter < WIDTH-1: shift one position (MSB_FIRST: left; else right), then counter++.
- SHIFT, counter = WIDTH-1:
  - If a new word is accepted at this edge: reload, counter = 0, stay in SHIFT. No idle gap; serial_valid stays high.
  - Otherwise: go to IDLE.
- Each word occupies exactly WIDTH consecutive serial_valid cycles.
- Outputs are derived from registers only; there is no combinational din -> serial_out path.
  - serial_out = shift-register MSB (MSB_FIRST = 1) or LSB (MSB_FIRST = 0) in SHIFT; IDLE_LEVEL in IDLE.
  - serial_valid = (state == SHIFT).
  - frame_done = serial_valid && counter == WIDTH-1.
  - bit_index = counter.
- Boundary conditions:
  - din_valid asserted while din_ready = 0: ignored. The current word is not corrupted, and din is not sampled.
  - din changing while not accepted: no effect.
  - Reset mid-word: the word is discarded with no partial flush. After release the block is in IDLE and accepts on the first valid edge.
  - Counter never exceeds WIDTH-1; there is no wrap beyond a word.

Test Plan:
1. Reset: hold rst_n=0 for 15 ns, drive din_valid=1 -> serial_out=0, serial_valid=0, din_ready=1, frame_done=0 throughout; no word accepted.
2. Single word, defaults: din=8'b1010_0000 accepted at edge T -> cycles T+1..T+8 give serial_out 1,0,1,0,0,0,0,0 with serial_valid=1 and bit_index 0..7; frame_done only at T+8; IDLE at T+9. A detector fed this stream pulses out exactly once, on the third bit.
3. Back-to-back: din_valid held with words 8'hA5 then 8'h5A -> 16 consecutive serial_valid cycles giving 1,0,1,0,0,1,0,1,0,1,0,1,1,0,1,0; din_ready high only in IDLE and on bit 7; frame_done pulses twice.
4. LSB-first: MSB_FIRST=0, din=8'h0D -> serial_out 1,0,1,1,0,0,0,0; frame_done on the 8th bit.
5. Busy rejection: accept 8'hFF, then drive din=8'h00 with din_valid=1 on bits 2..5 -> din_ready=0 during those cycles; serial_out stays 1 for all 8 bits; 8'h00 is accepted only at the bit-7 edge.
6. Reset mid-word: accept 8'hA5, assert rst_n=0 asynchronously after 3 bits -> serial_valid=0 and serial_out=0 immediately. After release, a new 8'h80 is accepted and emits 1,0,0,0,0,0,0,0 with no residue from 8'hA5.
